ram_arbiter: RTL and testbench

Round-robin arbiter that shares one single_port_ram instance between NUM_REQ independent requesters. It accepts a read or write from each requester through a valid/done handshake and issues one RAM access at a time. It returns read data and a per-requester completion pulse, and flags a timeout if the RAM never answers. It sits between client blocks (UART loader, display fetch, CPU port, and similar) and the RAM.

---
 rtl/ram_arbiter_pkg.sv | 20 ++
 rtl/ram_arbiter_rr_picker.sv | 29 ++
 rtl/ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding, default timeout
// and the pointer wrap helper.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 15;
  localparam int CNT_WIDTH       = 8;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_next(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester found when
// searching from ptr upward with wrap-around.
module rr_picker
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [IDX_WIDTH-1:0] cand_s;

  // Walk offsets from farthest to nearest so the closest hit to ptr wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
      found  = found | req[cand_s];
      idx    = req[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters,
// one access at a time, with a bounded wait for the RAM's ready pulse.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            resp_done,
  output logic                          resp_err,
  output logic [WIDTH-1:0]              resp_rdata,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy,
  output logic                          ram_request,
  output logic                          ram_write_enable,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [WIDTH-1:0]              ram_write_data,
  input  logic [WIDTH-1:0]              ram_read_data,
  input  logic                          ram_ready
);

  arb_state_e           state_r, state_next_s;
  logic [IDX_WIDTH-1:0] ptr_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 write_r;

  logic                  found_s;
  logic [IDX_WIDTH-1:0]  pick_idx_s;
  logic                  sel_write_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [WIDTH-1:0]      sel_wdata_s;
  logic                  take_s;
  logic                  done_set_s;
  logic                  err_s;
  logic                  cap_s;
  logic                  cnt_inc_s;

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_picker (
    .req  (req_valid),
    .ptr  (ptr_r),
    .found(found_s),
    .idx  (pick_idx_s)
  );

  // Only the winner's fields are ever looked at.
  assign sel_write_s = req_write[pick_idx_s];
  assign sel_addr_s  = req_addr[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata_s = req_wdata[int'(pick_idx_s)*WIDTH +: WIDTH];

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next_s = state_r;
    take_s       = 1'b0;
    done_set_s   = 1'b0;
    err_s        = 1'b0;
    cap_s        = 1'b0;
    cnt_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_next_s = ST_ISSUE;
          take_s       = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (ram_ready) begin
          state_next_s = ST_DONE;
          done_set_s   = 1'b1;
          cap_s        = ~write_r;
        end else if (cnt_r == CNT_WIDTH'(TIMEOUT)) begin
          state_next_s = ST_DONE;
          done_set_s   = 1'b1;
          err_s        = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
          cnt_inc_s    = 1'b1;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, latched request, timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      ptr_r            <= '0;
      cnt_r            <= '0;
      write_r          <= 1'b0;
      grant_idx        <= '0;
      busy             <= 1'b0;
      resp_done        <= '0;
      resp_err         <= 1'b0;
      resp_rdata       <= '0;
      ram_request      <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_addr         <= '0;
      ram_write_data   <= '0;
    end else begin
      state_r          <= state_next_s;
      busy             <= (state_next_s != ST_IDLE);
      ram_request      <= take_s;
      ram_write_enable <= take_s & sel_write_s;
      resp_done        <= done_set_s ? (NUM_REQ'(1'b1) << grant_idx) : '0;
      resp_err         <= done_set_s & err_s;
      if (take_s) begin
        grant_idx      <= pick_idx_s;
        write_r        <= sel_write_s;
        ram_addr       <= sel_addr_s;
        ram_write_data <= sel_wdata_s;
      end
      if (cap_s) begin
        resp_rdata <= ram_read_data;
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= '0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_WIDTH'(1);
      end
      if (state_r == ST_DONE) begin
        ptr_r <= IDX_WIDTH'(wrap_next(int'(grant_idx), NUM_REQ));
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter (4-requester build plus a
// 1-requester build), each driving a small single-port RAM stub.
module tb_ram_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [N-1:0]    resp_done;
  logic            resp_err;
  logic [W-1:0]    resp_rdata;
  logic [1:0]      grant_idx;
  logic            busy;
  logic            ram_request, ram_write_enable, ram_ready;
  logic [AW-1:0]   ram_addr;
  logic [W-1:0]    ram_write_data, ram_read_data;

  logic [0:0]    s1_valid, s1_write, s1_done, s1_grant;
  logic [AW-1:0] s1_addr, s1_ram_addr;
  logic [W-1:0]  s1_wdata, s1_rdata, s1_ram_wdata, s1_ram_rdata;
  logic          s1_err, s1_busy, s1_ram_req, s1_ram_we, s1_ram_ready;

  ram_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .grant_idx(grant_idx), .busy(busy),
    .ram_request(ram_request), .ram_write_enable(ram_write_enable), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .ram_ready(ram_ready)
  );

  ram_arbiter #(.NUM_REQ(1), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(s1_valid), .req_write(s1_write), .req_addr(s1_addr), .req_wdata(s1_wdata),
    .resp_done(s1_done), .resp_err(s1_err), .resp_rdata(s1_rdata),
    .grant_idx(s1_grant), .busy(s1_busy),
    .ram_request(s1_ram_req), .ram_write_enable(s1_ram_we), .ram_addr(s1_ram_addr),
    .ram_write_data(s1_ram_wdata), .ram_read_data(s1_ram_rdata), .ram_ready(s1_ram_ready)
  );

  // RAM stubs: ready one cycle after a sampled request unless stalled.
  logic [W-1:0]  mem  [256];
  logic [W-1:0]  mem1 [256];
  logic          stall, pre_we;
  logic [AW-1:0] pre_addr;
  logic [W-1:0]  pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr]  <= pre_data;
      mem1[pre_addr] <= pre_data;
    end
    ram_ready    <= reset ? 1'b0 : (ram_request & ~stall);
    s1_ram_ready <= reset ? 1'b0 : s1_ram_req;
    if (ram_request) begin
      if (ram_write_enable) mem[ram_addr] <= ram_write_data;
      ram_read_data <= mem[ram_addr];
    end
    if (s1_ram_req) begin
      if (s1_ram_we) mem1[s1_ram_addr] <= s1_ram_wdata;
      s1_ram_rdata <= mem1[s1_ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]   idx;
    logic         err;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_done_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*W +: W]   = d;
    req_valid[i]          = 1'b1;
  endtask

  task automatic push(input int i, input logic err, input logic [W-1:0] rd);
    exp_t e;
    e.idx = 2'(i); e.err = err; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for a done pulse, compare it with the scoreboard head, retire that request.
  task automatic wait_done(input int bound);
    int   n = 0;
    exp_t e;
    logic [N-1:0] onehot;
    do begin
      tick();
      n++;
    end while (resp_done == '0 && n < bound);
    check("done_seen", {31'd0, |resp_done}, 32'd1);
    if (|resp_done) begin
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        onehot = 4'b0001 << e.idx;
        check("done_vec", resp_done, onehot);
        check("resp_err", resp_err, e.err);
        check("resp_rdata", resp_rdata, e.rdata);
        req_valid[e.idx] = 1'b0;
      end
      last_done_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int c0, issue_c, prev, nd;
    reset = 1'b1; stall = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    s1_valid = '0; s1_write = '0; s1_addr = '0; s1_wdata = '0;

    preload(8'h12, 8'hA5);
    preload(8'h20, 8'h10);
    preload(8'h21, 8'h21);
    preload(8'h22, 8'h32);
    preload(8'h23, 8'h43);
    preload(8'h05, 8'h77);
    tick();
    check("rst_done", resp_done, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ram_request", ram_request, 1'b0);
    check("rst_grant", grant_idx, 2'd0);
    check("rst_err", resp_err, 1'b0);
    check("rst_rdata", resp_rdata, 8'h00);
    reset = 1'b0;
    tick();

    // Single read on requester 1: request in cycle 1, done in cycle 3.
    c0 = cyc;
    set_req(1, 1'b0, 8'h12, 8'h00);
    push(1, 1'b0, 8'hA5);
    tick();
    check("rd_ram_request", ram_request, 1'b1);
    check("rd_ram_addr", ram_addr, 8'h12);
    check("rd_ram_we", ram_write_enable, 1'b0);
    check("rd_grant", grant_idx, 2'd1);
    check("rd_busy", busy, 1'b1);
    wait_done(6);
    check("rd_latency", cyc - c0, 32'd3);
    tick();
    check("rd_idle_busy", busy, 1'b0);
    check("rd_idle_req", ram_request, 1'b0);

    // Four simultaneous reads from ptr 0, then 0 and 3 together.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h20 + i), 8'h00);
    push(0, 1'b0, 8'h10); push(1, 1'b0, 8'h21); push(2, 1'b0, 8'h32); push(3, 1'b0, 8'h43);
    prev = 0;
    for (int i = 0; i < N; i++) begin
      wait_done(8);
      if (i > 0) check("rr_spacing", last_done_cyc - prev, 32'd4);
      prev = last_done_cyc;
    end
    set_req(0, 1'b0, 8'h20, 8'h00);
    set_req(3, 1'b0, 8'h23, 8'h00);
    push(0, 1'b0, 8'h10); push(3, 1'b0, 8'h43);
    wait_done(8);
    wait_done(8);

    // Write 0x3C to 0x40 from requester 2, read it back from requester 0.
    set_req(2, 1'b1, 8'h40, 8'h3C);
    push(2, 1'b0, 8'h43);
    wait_done(8);
    set_req(0, 1'b0, 8'h40, 8'h00);
    push(0, 1'b0, 8'h3C);
    wait_done(8);

    // Timeout on requester 1 with requester 3 queued behind it.
    stall = 1'b1;
    set_req(1, 1'b0, 8'h12, 8'h00);
    set_req(3, 1'b0, 8'h22, 8'h00);
    push(1, 1'b1, 8'h3C);
    push(3, 1'b0, 8'h32);
    for (int k = 0; k < 4 && !ram_request; k++) tick();
    check("to_issue_seen", ram_request, 1'b1);
    check("to_grant", grant_idx, 2'd1);
    issue_c = cyc;
    wait_done(30);
    check("to_latency", cyc - issue_c, 32'd17);
    stall = 1'b0;
    wait_done(8);

    // Move ptr to 2, then reset in the middle of a WAIT.
    set_req(1, 1'b1, 8'h50, 8'h11);
    push(1, 1'b0, 8'h32);
    wait_done(8);
    stall = 1'b1;
    set_req(2, 1'b0, 8'h20, 8'h00);
    tick();
    tick();
    check("wr_wait_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("rw_done", resp_done, 4'h0);
    check("rw_busy", busy, 1'b0);
    check("rw_ram_request", ram_request, 1'b0);
    check("rw_grant", grant_idx, 2'd0);
    check("rw_rdata", resp_rdata, 8'h00);
    check("rw_ram_addr", ram_addr, 8'h00);
    req_valid = '0;
    stall = 1'b0;
    tick();
    check("rw_no_done", resp_done, 4'h0);
    reset = 1'b0;
    set_req(3, 1'b0, 8'h40, 8'h00);
    set_req(1, 1'b0, 8'h12, 8'h00);
    push(1, 1'b0, 8'hA5);
    push(3, 1'b0, 8'h3C);
    wait_done(8);
    wait_done(8);
    check("sb_drained", exp_q.size(), 32'd0);

    // Single-requester build: back-to-back reads with valid held high.
    c0 = cyc;
    nd = 0;
    s1_addr = 8'h05;
    s1_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("s1_grant", s1_grant, 1'b0);
      if (s1_done[0]) begin
        check("s1_latency", cyc - c0, 32'(3 + 4 * nd));
        check("s1_rdata", s1_rdata, 8'h77);
        check("s1_err", s1_err, 1'b0);
        nd++;
        if (nd == 3) s1_valid = 1'b0;
      end
    end
    check("s1_count", nd, 32'd3);
    tick();
    tick();
    check("s1_idle", s1_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
